// File: rtl/clock_pkg.sv
// Shared constants and set-FSM encoding for the time-of-day clock.
package clock_pkg;

  localparam int         MS_MAX_DEFAULT = 999;
  localparam logic [7:0] BCD_SEC_MAX    = 8'h59;
  localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_REJECT = 2'd3
  } set_state_t;

  // A BCD pair is legal when both nibbles are decimal and it does not pass {tens_max, units_max}.
  function automatic logic bcd_in_range(input logic [7:0] val,
                                        input logic [3:0] tens_max,
                                        input logic [3:0] units_max_at_tens_max);
    logic [3:0] w_tens;
    logic [3:0] w_units;
    w_tens  = val[7:4];
    w_units = val[3:0];
    return (w_units <= 4'd9) && (w_tens <= tens_max) &&
           ((w_tens != tens_max) || (w_units <= units_max_at_tens_max));
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps to 00 after {TENS_MAX, UNITS_MAX_AT_TENS_MAX}.
module bcd_mod_counter #(
  parameter logic [3:0] TENS_MAX              = 4'd5,
  parameter logic [3:0] UNITS_MAX_AT_TENS_MAX = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic       carry
);

  logic [3:0] r_tens;
  logic [3:0] r_units;
  logic       w_at_max;

  assign w_at_max = (r_tens == TENS_MAX) && (r_units == UNITS_MAX_AT_TENS_MAX);
  assign carry    = inc && w_at_max;
  assign val      = {r_tens, r_units};

  // A load always overrides a simultaneous increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tens  <= 4'd0;
      r_units <= 4'd0;
    end else if (load) begin
      r_tens  <= load_val[7:4];
      r_units <= load_val[3:0];
    end else if (inc) begin
      if (w_at_max) begin
        r_tens  <= 4'd0;
        r_units <= 4'd0;
      end else if (r_units == 4'd9) begin
        r_tens  <= r_tens + 4'd1;
        r_units <= 4'd0;
      end else begin
        r_units <= r_units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD time of day advanced by the upstream millisecond wrap, with a
// validated time-set handshake.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int MS_W   = 10,
  parameter int MS_MAX = MS_MAX_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reconfig_en,
  input  logic [MS_W-1:0] ms_in,
  input  logic            set_valid,
  output logic            set_ready,
  input  logic [7:0]      set_hh,
  input  logic [7:0]      set_mm,
  input  logic [7:0]      set_ss,
  output logic            set_done,
  output logic            set_err,
  output logic [7:0]      hh,
  output logic [7:0]      mm,
  output logic [7:0]      ss,
  output logic            sec_tick,
  output logic            day_tick
);

  set_state_t      r_state;
  set_state_t      w_state_nxt;
  logic [MS_W-1:0] r_ms_prev;
  logic [7:0]      r_cap_hh;
  logic [7:0]      r_cap_mm;
  logic [7:0]      r_cap_ss;
  logic            r_sec_tick;
  logic            r_day_tick;
  logic            r_set_done;
  logic            r_set_err;
  logic            w_wrap;
  logic            w_inc;
  logic            w_accept;
  logic            w_load;
  logic            w_reject;
  logic            w_ready;
  logic            w_cap_ok;
  logic            w_ss_carry;
  logic            w_mm_carry;
  logic            w_hh_carry;

  assign w_wrap = (r_ms_prev == MS_W'(MS_MAX)) && (ms_in == '0) && !reconfig_en;
  // The load edge and the LOAD cycle both swallow a wrap so the set time is shown unmodified.
  assign w_inc  = w_wrap && !w_load && (r_state != ST_LOAD);

  assign w_cap_ok = bcd_in_range(r_cap_ss, BCD_SEC_MAX[7:4], BCD_SEC_MAX[3:0]) &&
                    bcd_in_range(r_cap_mm, BCD_SEC_MAX[7:4], BCD_SEC_MAX[3:0]) &&
                    bcd_in_range(r_cap_hh, BCD_HOUR_MAX[7:4], BCD_HOUR_MAX[3:0]);

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_reject    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready = !reconfig_en;
        if (set_valid && w_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!reconfig_en) begin
          if (w_cap_ok) begin
            w_load      = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_reject    = 1'b1;
            w_state_nxt = ST_REJECT;
          end
        end
      end
      ST_LOAD, ST_REJECT: begin
        if (!reconfig_en) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ms_prev  <= '0;
      r_sec_tick <= 1'b0;
      r_day_tick <= 1'b0;
      r_set_done <= 1'b0;
      r_set_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ms_prev  <= ms_in;
      r_sec_tick <= w_inc;
      r_day_tick <= w_hh_carry;
      r_set_done <= w_load;
      r_set_err  <= w_reject;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_cap_hh <= set_hh;
      r_cap_mm <= set_mm;
      r_cap_ss <= set_ss;
    end
  end

  bcd_mod_counter #(
    .TENS_MAX             (BCD_SEC_MAX[7:4]),
    .UNITS_MAX_AT_TENS_MAX(BCD_SEC_MAX[3:0])
  ) u_ss (
    .clk     (clk),
    .reset   (reset),
    .inc     (w_inc),
    .load    (w_load),
    .load_val(r_cap_ss),
    .val     (ss),
    .carry   (w_ss_carry)
  );

  bcd_mod_counter #(
    .TENS_MAX             (BCD_SEC_MAX[7:4]),
    .UNITS_MAX_AT_TENS_MAX(BCD_SEC_MAX[3:0])
  ) u_mm (
    .clk     (clk),
    .reset   (reset),
    .inc     (w_ss_carry),
    .load    (w_load),
    .load_val(r_cap_mm),
    .val     (mm),
    .carry   (w_mm_carry)
  );

  bcd_mod_counter #(
    .TENS_MAX             (BCD_HOUR_MAX[7:4]),
    .UNITS_MAX_AT_TENS_MAX(BCD_HOUR_MAX[3:0])
  ) u_hh (
    .clk     (clk),
    .reset   (reset),
    .inc     (w_mm_carry),
    .load    (w_load),
    .load_val(r_cap_hh),
    .val     (hh),
    .carry   (w_hh_carry)
  );

  assign set_ready = w_ready;
  assign set_done  = r_set_done;
  assign set_err   = r_set_err;
  assign sec_tick  = r_sec_tick;
  assign day_tick  = r_day_tick;

endmodule
